// File: rtl/jogador_pkg.sv
// Shared types and sizes for the memory-game auto-player.
package jogador_pkg;

  localparam int unsigned MEM_DEPTH = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned PAT_W     = 4;
  localparam int unsigned N_W       = ADDR_W + 1;  // item count spans 0..16
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PULSO_JOGAR = 4'd1,
    OBSERVA     = 4'd2,
    PRESSIONA   = 4'd3,
    SOLTA       = 4'd4,
    FIM         = 4'd5
  } estado_t;

  function automatic logic one_hot(input logic [PAT_W-1:0] v);
    return (v != '0) && ((v & (v - PAT_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Game-side signals shared between the auto-player (master) and the game (slave).
interface jogador_automatico_if;
  import jogador_pkg::*;

  logic [PAT_W-1:0] leds;
  logic             ganhou;
  logic             perdeu;
  logic [PAT_W-1:0] botoes;
  logic             jogar;

  modport master (input leds, ganhou, perdeu, output botoes, jogar);
  modport slave  (output leds, ganhou, perdeu, input botoes, jogar);
endinterface

// File: rtl/memoria_jogadas.sv
// 16x4 sequence memory: synchronous write, asynchronous read, contents not reset.
module memoria_jogadas
  import jogador_pkg::*;
(
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PAT_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PAT_W-1:0]  rdata_o
);

  logic [PAT_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jogador_automatico.sv
// Auto-player: records each round's LED event and replays the stored sequence as presses.
// Optional macro JOGADOR_ERRO_INJETADO_EN corrupts one chosen press to exercise the lose path.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int unsigned START_CYCLES = 5,
  parameter int unsigned HOLD_CYCLES  = 5,
  parameter int unsigned GAP_CYCLES   = 5,
  parameter int unsigned IDLE_CYCLES  = 8,
  parameter int unsigned ERRO_RODADA  = 3,
  parameter int unsigned ERRO_JOGADA  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  jogador_automatico_if.master     jogo,
  output logic                     ativo,
  output logic                     fim,
  output logic                     erro_leds,
  output logic [3:0]               db_rodada,
  output logic [3:0]               db_estado
);

  estado_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [N_W-1:0]   j_q, j_d;
  logic [3:0]       rodada_q, rodada_d;
  logic             erro_q, erro_d;
  logic             pend_q, pend_d;
  logic [PAT_W-1:0] leds_d_q;
  logic             mem_we;
  logic [PAT_W-1:0] mem_rdata;
  logic             evento_c;
  logic             injeta_c;

  memoria_jogadas u_mem (
    .clock   (clock),
    .we_i    (mem_we),
    .waddr_i (n_q[ADDR_W-1:0]),
    .wdata_i (jogo.leds),
    .raddr_i (j_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  assign evento_c = (leds_d_q == '0) && (jogo.leds != '0);

`ifdef JOGADOR_ERRO_INJETADO_EN
  assign injeta_c = (rodada_q == 4'(ERRO_RODADA)) && (j_q == N_W'(ERRO_JOGADA));
`else
  logic unused_erro_params;
  assign injeta_c           = 1'b0;
  assign unused_erro_params = ^{32'(ERRO_RODADA), 32'(ERRO_JOGADA)};
`endif

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INICIAL;
      cnt_q    <= '0;
      idle_q   <= '0;
      n_q      <= '0;
      j_q      <= '0;
      rodada_q <= '0;
      erro_q   <= 1'b0;
      pend_q   <= 1'b0;
      leds_d_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      n_q      <= n_d;
      j_q      <= j_d;
      rodada_q <= rodada_d;
      erro_q   <= erro_d;
      pend_q   <= pend_d;
      leds_d_q <= jogo.leds;
    end
  end

  // Next state; a start request wipes the recorded sequence as PULSO_JOGAR begins
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    n_d      = n_q;
    j_d      = j_q;
    rodada_d = rodada_q;
    erro_d   = erro_q;
    pend_d   = pend_q;
    mem_we   = 1'b0;

    unique case (state_q)
      INICIAL, FIM: begin
        if (iniciar) begin
          state_d  = PULSO_JOGAR;
          cnt_d    = '0;
          idle_d   = '0;
          n_d      = '0;
          j_d      = '0;
          rodada_d = '0;
          erro_d   = 1'b0;
          pend_d   = 1'b0;
        end
      end
      PULSO_JOGAR: begin
        if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
          state_d = OBSERVA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OBSERVA: begin
        if (idle_q == CNT_W'(IDLE_CYCLES)) begin
          state_d = PRESSIONA;
          cnt_d   = '0;
          idle_d  = '0;
          j_d     = '0;
          pend_d  = 1'b0;
        end else begin
          if (evento_c) begin
            if (one_hot(jogo.leds) && (n_q < N_W'(MEM_DEPTH))) begin
              mem_we = 1'b1;
              n_d    = n_q + N_W'(1);
              pend_d = 1'b1;
            end else begin
              erro_d = 1'b1;
            end
          end
          if (jogo.leds != '0) idle_d = '0;
          else if (pend_q)     idle_d = idle_q + CNT_W'(1);
        end
      end
      PRESSIONA: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = SOLTA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SOLTA: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          j_d   = j_q + N_W'(1);
          if ((j_q + N_W'(1)) == n_q) begin
            state_d  = OBSERVA;
            rodada_d = rodada_q + 4'd1;
          end else begin
            state_d = PRESSIONA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = INICIAL;
    endcase

    // Game over overrides everything while the player is running
    if ((jogo.ganhou || jogo.perdeu) && (state_q != INICIAL) && (state_q != FIM)) begin
      state_d = FIM;
    end
  end

  // Moore output decode
  always_comb begin
    jogo.botoes = '0;
    jogo.jogar  = (state_q == PULSO_JOGAR);
    ativo       = (state_q != INICIAL) && (state_q != FIM);
    fim         = (state_q == FIM);
    erro_leds   = erro_q;
    db_rodada   = rodada_q;
    db_estado   = state_q;
    if (state_q == PRESSIONA) begin
      if (injeta_c) jogo.botoes = (mem_rdata == 4'b0001) ? 4'b0010 : 4'b0001;
      else          jogo.botoes = mem_rdata;
    end
  end

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: record/replay timing, errors, abort, wrap and reset.
module tb_jogador_automatico;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       ativo;
  logic       fim;
  logic       erro_leds;
  logic [3:0] db_rodada;
  logic [3:0] db_estado;

  jogador_automatico_if jogo ();

  jogador_automatico dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogo      (jogo),
    .ativo     (ativo),
    .fim       (fim),
    .erro_leds (erro_leds),
    .db_rodada (db_rodada),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [3:0] seq [16];
  int         n_seq      = 0;
  int         rodada_esp = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic verifica(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference for the press value of item j during the replay with index r
  function automatic int esperado(input int r, input int j);
    logic [3:0] v;
    v = seq[j];
`ifdef JOGADOR_ERRO_INJETADO_EN
    if (r == 3 && j == 1) v = (seq[j] == 4'b0001) ? 4'b0010 : 4'b0001;
`endif
    return int'(v);
  endfunction

  task automatic inicia();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int k = 0; k < 5; k++) begin
      verifica("jogar_alto", int'(jogo.jogar), 1);
      tick();
    end
    verifica("jogar_baixo", int'(jogo.jogar), 0);
    verifica("estado_observa", int'(db_estado), 2);
    verifica("rodada_limpa", int'(db_rodada), 0);
    verifica("erro_limpo", int'(erro_leds), 0);
    verifica("ativo_observa", int'(ativo), 1);
    n_seq      = 0;
    rodada_esp = 0;
  endtask

  // One LED event followed by idle; leaves the bench on the first press cycle
  task automatic mostra(input logic [3:0] p);
    jogo.leds = p;
    repeat (3) tick();
    jogo.leds = 4'b0000;
    repeat (8) tick();
    verifica("pre_press_botoes", int'(jogo.botoes), 0);
    verifica("pre_press_estado", int'(db_estado), 2);
    tick();
  endtask

  task automatic rodada(input logic [3:0] p);
    seq[n_seq] = p;
    n_seq++;
    mostra(p);
    for (int i = 0; i < n_seq; i++) begin
      for (int h = 0; h < 5; h++) begin
        verifica("press_botoes", int'(jogo.botoes), esperado(rodada_esp, i));
        tick();
      end
      for (int g = 0; g < 5; g++) begin
        verifica("gap_botoes", int'(jogo.botoes), 0);
        tick();
      end
    end
    rodada_esp = (rodada_esp + 1) % 16;
    verifica("db_rodada", int'(db_rodada), rodada_esp);
    verifica("volta_observa", int'(db_estado), 2);
  endtask

  initial begin
    reset       = 1'b1;
    iniciar     = 1'b0;
    jogo.leds   = 4'b0000;
    jogo.ganhou = 1'b0;
    jogo.perdeu = 1'b0;
    repeat (2) tick();
    verifica("rst_botoes", int'(jogo.botoes), 0);
    verifica("rst_jogar", int'(jogo.jogar), 0);
    verifica("rst_ativo", int'(ativo), 0);
    verifica("rst_fim", int'(fim), 0);
    verifica("rst_erro", int'(erro_leds), 0);
    verifica("rst_rodada", int'(db_rodada), 0);
    verifica("rst_estado", int'(db_estado), 0);
    reset = 1'b0;
    tick();
    verifica("inicial_espera", int'(db_estado), 0);

    // Three growing rounds, then a bad pattern, then the four-item replay
    inicia();
    rodada(4'b0001);
    rodada(4'b0010);
    rodada(4'b0100);
    jogo.leds = 4'b0011;
    tick();
    verifica("erro_nao_one_hot", int'(erro_leds), 1);
    jogo.leds = 4'b0000;
    repeat (12) tick();
    verifica("sem_replay_apos_erro", int'(db_estado), 2);
    rodada(4'b1000);
    verifica("erro_pegajoso", int'(erro_leds), 1);

    // Loss during a press
    seq[n_seq] = 4'b0001;
    n_seq++;
    mostra(4'b0001);
    verifica("aborta_press", int'(jogo.botoes), int'(seq[0]));
    jogo.perdeu = 1'b1;
    tick();
    jogo.perdeu = 1'b0;
    verifica("perdeu_botoes", int'(jogo.botoes), 0);
    verifica("perdeu_fim", int'(fim), 1);
    verifica("perdeu_estado", int'(db_estado), 5);
    verifica("perdeu_ativo", int'(ativo), 0);
    repeat (3) tick();
    verifica("fim_estavel", int'(db_estado), 5);

    // Restart from FIM; sixteen rounds wrap db_rodada and fill memory
    inicia();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] p;
      p = 4'b0001 << (i % 4);
      rodada(p);
    end
    verifica("rodada_wrap", int'(db_rodada), 0);
    verifica("sem_erro_16", int'(erro_leds), 0);
    jogo.leds = 4'b0010;
    tick();
    verifica("erro_overflow", int'(erro_leds), 1);
    jogo.leds = 4'b0000;
    repeat (12) tick();
    verifica("sem_replay_overflow", int'(db_estado), 2);
    jogo.ganhou = 1'b1;
    tick();
    jogo.ganhou = 1'b0;
    verifica("ganhou_fim", int'(fim), 1);
    verifica("ganhou_estado", int'(db_estado), 5);

    // Restart clears the stored sequence; then reset in the middle of a press
    inicia();
    rodada(4'b0100);
    mostra(4'b1000);
    verifica("press_antes_reset", int'(jogo.botoes), 4);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    verifica("mrst_botoes", int'(jogo.botoes), 0);
    verifica("mrst_jogar", int'(jogo.jogar), 0);
    verifica("mrst_fim", int'(fim), 0);
    verifica("mrst_erro", int'(erro_leds), 0);
    verifica("mrst_estado", int'(db_estado), 0);
    verifica("mrst_rodada", int'(db_rodada), 0);
    tick();
    verifica("mrst_fica_inicial", int'(db_estado), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/jogador_automatico.md
# jogador_automatico

Hardware auto-player for the memory game: the driver side of the game's `leds`/`botoes` interface. It pulses `jogar`, watches the LED pattern the game lights each round, stores it in a 16-entry sequence memory, and replays the whole stored sequence as timed button presses. It sits beside `circuito_jogo_base` on the FPGA top level, or in a bench, so the game can be exercised without a human. It stops when the game reports `ganhou` or `perdeu`.

## Interface
Parameters:
- `START_CYCLES`, 5, cycles `jogar` is held high
- `HOLD_CYCLES`, 5, cycles each button pattern is held
- `GAP_CYCLES`, 5, cycles of `botoes=0000` after each press
- `IDLE_CYCLES`, 8, consecutive `leds==0000` cycles after a recorded item before replay starts
- `ERRO_RODADA`, 3, replay index that gets the injected error (only with macro)
- `ERRO_JOGADA`, 1, press index that gets the injected error (only with macro)

Ports:
- `clock`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-high
- `iniciar`  in  1  start/restart request, sampled in INICIAL and FIM
- `leds`  in  4  game LED output, one-hot or 0000
- `ganhou`  in  1  game won
- `perdeu`  in  1  game lost
- `botoes`  out  4  button stimulus to the game
- `jogar`  out  1  start pulse to the game
- `ativo`  out  1  high in every state except INICIAL and FIM
- `fim`  out  1  high in FIM
- `erro_leds`  out  1  sticky: non-one-hot LED pattern or memory overflow seen
- `db_rodada`  out  4  completed replays, mod 16
- `db_estado`  out  4  state encoding

## Operation
- States: INICIAL=0, PULSO_JOGAR=1, OBSERVA=2, PRESSIONA=3, SOLTA=4, FIM=5.
- INICIAL: all outputs 0; `iniciar=1` -> PULSO_JOGAR.
- PULSO_JOGAR: `jogar=1`; clears item count `n`, press index `j`, `db_rodada`, `erro_leds`, and pending flag; after START_CYCLES -> OBSERVA.
- OBSERVA: rising event is `leds_d==0000 && leds!=0000`, where `leds_d` is `leds` registered one cycle.
  - One-hot event with `n<16`: write `mem[n]<=leds`, `n++`, set pending.
  - Non-one-hot event, or event with `n==16`: ignore it, set `erro_leds`.
  - Idle counter clears when `leds!=0` and increments while `leds==0` and pending.
  - When the counter reaches IDLE_CYCLES: `j<=0`, clear pending, -> PRESSIONA.
- PRESSIONA: `botoes=mem[j]` for HOLD_CYCLES -> SOLTA.
- SOLTA: `botoes=0000` for GAP_CYCLES, then `j++`.
  - If the new `j==n`: `db_rodada++` (wraps 15->0), -> OBSERVA.
  - Else -> PRESSIONA.
- Abort: `ganhou` or `perdeu` sampled high in any state other than INICIAL/FIM -> FIM next edge. This takes priority over all other transitions.
- FIM: `botoes=0`, `fim=1`; `iniciar=1` -> PULSO_JOGAR, which clears memory state.
- LED events arriving during PRESSIONA/SOLTA are not recorded. `leds_d` keeps updating in those states.

## Timing
- Moore outputs, decoded from registered state and counters. No combinational path from inputs to outputs.
- Every output is 0 at reset, and `db_estado=INICIAL`.
- `jogar` is high for exactly START_CYCLES cycles, starting the cycle after `iniciar` is sampled.
- First press starts IDLE_CYCLES+1 cycles after `leds` returns to 0000.
- One replay of `n` items takes `n*(HOLD_CYCLES+GAP_CYCLES)` cycles.
- `botoes` drops to 0000 on the edge after `ganhou`/`perdeu` is sampled.
- `reset` mid-operation returns to INICIAL on the next edge. `mem` contents are don't-care after reset.

## Configuration
- Macro: `JOGADOR_ERRO_INJETADO_EN`.
- Defined: on the press where `db_rodada==ERRO_RODADA && j==ERRO_JOGADA`, drive `4'b0001`. If `mem[j]` is already `4'b0001`, drive `4'b0010` instead. Used to exercise the game's `perdeu` path.
- Undefined: `botoes=mem[j]` always. Parameters ERRO_RODADA and ERRO_JOGADA are unused.

## Structure
- Package `jogador_pkg` holds the state enum/encoding, `MEM_DEPTH=16`, the address width (4), and the pattern width (4).
- Sub-module `memoria_jogadas` is a 16x4 register file: synchronous write, asynchronous read, no reset.
- The FSM and counters live in the top module.

## Test plan
- Reset asserted mid-replay -> next cycle `botoes=0`, `jogar=0`, `fim=0`, `erro_leds=0`, `db_estado=0`.
- `iniciar` for 1 cycle -> `jogar=1` for exactly 5 cycles, then `db_estado=2`.
- `leds=0001` for 3 cycles, then 0000 -> 9 cycles later `botoes=0001` for 5 cycles, then 0000 for 5 cycles, then `db_rodada=1`.
- Three rounds showing 0001, 0010, 0100 -> third replay drives 0001, 0010, 0100, each for 5 cycles with 5-cycle gaps; then `db_rodada=3`.
- `leds=0011` event -> not stored, `erro_leds=1`. `perdeu=1` during PRESSIONA -> `botoes=0000` and `fim=1` next cycle.
- Macro defined, sequence 0001, 0010, 0100, 1000 -> in replay 3, press 1 drives 0001 instead of 0010; all other presses are unchanged.
